// File: rtl/alsu_sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer and its sum core.
// Holds default sizes, the FSM state encoding and the sum-width helper.
package alsu_sample_sequencer_pkg;

  localparam int DW_DEF    = 8;
  localparam int N_DEF     = 6;
  localparam int SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Width that holds n samples of dw bits without wrap.
  function automatic int sum_width(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

endpackage

// File: rtl/alsu_sum_core.sv
// Combinational frame sum, right shift and saturation to DW bits.
// Ports: i_slots (N*DW packed samples) -> o_sum (SW bits), o_result (DW bits).
module alsu_sum_core
  import alsu_sample_sequencer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int N     = N_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int SW    = sum_width(DW, N)
) (
  input  logic [N*DW-1:0] i_slots,
  output logic [SW-1:0]   o_sum,
  output logic [DW-1:0]   o_result
);

  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_shifted;

  // Every operand is widened to SW before adding so no partial sum wraps.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + SW'(i_slots[i*DW +: DW]);
    end
  end

  assign w_shifted = w_sum >> SHIFT;
  assign o_sum     = w_sum;

  // SW > DW always holds since N >= 2.
  always_comb begin
    if (|w_shifted[SW-1:DW]) begin
      o_result = '1;
    end else begin
      o_result = w_shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/alsu_sample_sequencer.sv
// Collects N serial samples, then emits (sum >> SHIFT) on a valid/ready port.
// Ports: clk, rst; in_valid/in_data/in_ready; flush;
//        out_valid/out_data/out_ready; fill_cnt; busy.
module alsu_sample_sequencer
  import alsu_sample_sequencer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int N     = N_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  input  logic                   out_ready,
  output logic [$clog2(N+1)-1:0] fill_cnt,
  output logic                   busy
);

  localparam int SW = sum_width(DW, N);
  localparam int CW = $clog2(N + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_fill;
  logic [N*DW-1:0] r_slots;
  logic [DW-1:0]   r_out_data;

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_last;
  logic [SW-1:0]   w_sum;
  logic [DW-1:0]   w_result;

  // Handshake outputs decode registered state only, so neither
  // out_ready nor in_valid reaches the opposite side combinationally.
  assign in_ready   = (r_state == COLLECT);
  assign out_valid  = (r_state == OUTPUT);
  assign out_data   = r_out_data;
  assign fill_cnt   = r_fill;
  assign busy       = (r_state != COLLECT) || (r_fill != '0);

  // A coincident flush drops the sample.
  assign w_in_xfer  = in_valid && in_ready && !flush;
  assign w_out_xfer = out_valid && out_ready;
  assign w_last     = (r_fill == CW'(N - 1));

  alsu_sum_core #(
    .DW    (DW),
    .N     (N),
    .SHIFT (SHIFT),
    .SW    (SW)
  ) u_sum (
    .i_slots  (r_slots),
    .o_sum    (w_sum),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      COLLECT: if (w_in_xfer && w_last) w_next = COMPUTE;
      COMPUTE: w_next = OUTPUT;
      OUTPUT:  if (w_out_xfer) w_next = COLLECT;
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
    end else if (r_state == COLLECT) begin
      if (flush) begin
        r_fill <= '0;
      end else if (w_in_xfer) begin
        r_fill <= r_fill + CW'(1);
      end
    end else if (w_out_xfer) begin
      r_fill <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots <= '0;
    end else if (w_in_xfer) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == r_fill) begin
          r_slots[i*DW +: DW] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
    end else if (r_state == COMPUTE) begin
      r_out_data <= w_result;
    end
  end

  logic [SW-1:0] w_unused_sum;
  assign w_unused_sum = w_sum;

endmodule

// File: tb/tb_alsu_sample_sequencer.sv
// Directed self-checking bench for alsu_sample_sequencer.
// Drives inputs #1 after each rising edge and checks outputs there.
module tb_alsu_sample_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] fill_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alsu_sample_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fill_cnt  (fill_cnt),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_fill"}, fill_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_reset_vals("rst");

    // Back-to-back frame 10..60 -> 210>>3 = 26
    for (int i = 1; i <= 6; i++) begin
      push(8'(i * 10));
      chk("t1_fill", fill_cnt, i);
    end
    chk("t1_ready_c", in_ready, 0);
    chk("t1_ovalid_c", out_valid, 0);
    chk("t1_busy_c", busy, 1);
    step();
    chk("t1_ovalid", out_valid, 1);
    chk("t1_odata", out_data, 26);
    chk("t1_ready_o", in_ready, 0);
    step();
    chk("t1_ovalid_done", out_valid, 0);
    chk("t1_ready_back", in_ready, 1);
    chk("t1_fill_done", fill_cnt, 0);
    chk("t1_busy_done", busy, 0);

    // Full-scale frame: 1530>>3 = 191
    for (int i = 0; i < 6; i++) push(8'd255);
    step();
    chk("t2_ovalid", out_valid, 1);
    chk("t2_odata", out_data, 191);
    step();
    chk("t2_ovalid_done", out_valid, 0);

    // Backpressure hold; extra in_valid and flush ignored
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i * 10));
    step();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      flush    = k[0];
      step();
      chk("t3_ovalid", out_valid, 1);
      chk("t3_odata", out_data, 26);
      chk("t3_ready", in_ready, 0);
      chk("t3_fill", fill_cnt, 6);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t3_ovalid_done", out_valid, 0);
    chk("t3_fill_done", fill_cnt, 0);
    chk("t3_ready_back", in_ready, 1);

    // Flush coincident with a 4th sample
    for (int i = 0; i < 3; i++) push(8'd100);
    chk("t4_fill3", fill_cnt, 3);
    flush = 1'b1;
    push(8'd200);
    flush = 1'b0;
    chk("t4_fill_flush", fill_cnt, 0);
    chk("t4_busy_flush", busy, 0);
    for (int i = 0; i < 6; i++) push(8'd8);
    step();
    chk("t4_ovalid", out_valid, 1);
    chk("t4_odata", out_data, 6);
    step();

    // Random gaps, samples 1..6 -> 21>>3 = 2
    for (int i = 1; i <= 6; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        chk("t5_fill_gap", fill_cnt, i - 1);
      end
      push(8'(i));
      chk("t5_fill", fill_cnt, i);
    end
    step();
    chk("t5_ovalid", out_valid, 1);
    chk("t5_odata", out_data, 2);
    step();

    // Reset mid-frame
    for (int i = 0; i < 4; i++) push(8'd50);
    chk("t6_fill4", fill_cnt, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("t6_midframe");

    // Reset while presenting a result (600>>3 = 75)
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'd100);
    step();
    chk("t6_ovalid_pre", out_valid, 1);
    chk("t6_odata_pre", out_data, 75);
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("t6_output");
    step();
    chk("t6_no_result", out_valid, 0);

    // Frame of 16s -> 96>>3 = 12
    for (int i = 0; i < 6; i++) push(8'd16);
    step();
    chk("t6_ovalid", out_valid, 1);
    chk("t6_odata", out_data, 12);
    step();
    chk("t6_ovalid_done", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
